alarm_bank_set: RTL
===================

Name: alarm_bank_set

Overview:
Multi-channel alarm setting and matching block for the digital watch, active while the mode selector is in alarm-set mode.
- Holds NUM_ALARMS independent alarm times, each with an enable bit.
- Edits the selected alarm digit by digit from the synchronised button pulses, in 12 h or 24 h format.
- Compares every enabled alarm against the running clock time and emits one hit pulse per match.
- Sits between the button synchroniser / mode FSM and the display mux / buzzer driver.

Parameters:
NUM_ALARMS, 4, number of alarm channels (1..8); SEL width is clog2(NUM_ALARMS), minimum 1.
ACTIVE_MODE, 4'b0000, MODE value in which editing is enabled.
H24, 0, 0 = 12 h format with meridiem (hours 0..11); 1 = 24 h format (hours 0..23, MERIDIEM held 0).

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous reset, active-high
NUM_SYNC  in  4  one-cycle button pulses: [0] value up, [1] value down, [2] cursor next, [3] cursor previous
MODE  in  4  current watch mode
CUR_MERIDIEM  in  1  running clock meridiem
CUR_HOUR  in  7  running clock hour, binary
CUR_MIN  in  7  running clock minute, binary
CUR_SEC  in  7  running clock second, binary
CURSOR  out  4  edit position
SEL  out  clog2(NUM_ALARMS)  selected alarm channel
MERIDIEM  out  1  selected alarm meridiem
HOUR  out  7  selected alarm hour
MIN  out  7  selected alarm minute
SEC  out  7  selected alarm second
ALARM_EN  out  NUM_ALARMS  per-channel enable bits
RING_HIT  out  NUM_ALARMS  registered one-cycle match pulses

Behaviour:
- Reset (RESET=1 at a CLK edge): CURSOR=0, SEL=0, every alarm=0/0:00:00, ALARM_EN=0, RING_HIT=0, previous-time register=0.
- Storage is binary: SEC 0..59, MIN 0..59, HOUR as set by H24.
- MERIDIEM, HOUR, MIN and SEC are a combinational view of channel SEL. An edit becomes visible the cycle after its pulse.
- Edits and cursor moves occur only when MODE==ACTIVE_MODE. In any other mode, all state except RING_HIT and the previous-time register holds.
- Cursor positions:
  - 0 sec ones, 1 sec tens, 2 min ones, 3 min tens, 4 hour ones, 5 hour tens
  - 6 meridiem toggle (H24=0 only)
  - 7 enable toggle of channel SEL
  - 8 channel select
- Cursor movement:
  - NUM_SYNC[2] alone moves to the next position; 8 wraps to 0.
  - NUM_SYNC[3] alone moves to the previous position; 0 wraps to 8.
  - With H24=1, position 6 is skipped in both directions.
  - [2] and [3] together: cursor unchanged.
- Value up/down: NUM_SYNC[0] alone = up, [1] alone = down, both together = ignored. An edit uses the cursor value before any cursor move in the same cycle; both updates take effect.
- Sec/min ones: the ones digit wraps within its tens (59 up -> 50; 50 down -> 59).
- Sec/min tens: up on value >=50 gives value-50, otherwise +10; down on value <10 gives value+50, otherwise -10.
- Hour ones, 12 h: tens 0 wraps 0..9; tens 1 wraps 10..11.
- Hour ones, 24 h: tens 0/1 wrap x0..x9; tens 2 wraps 20..23.
- Hour tens, 12 h (up and down): HOUR>=10 gives HOUR-10; HOUR<=1 gives HOUR+10; else HOUR=11.
- Hour tens, 24 h:
  - up cycles tens 0->1->2->0; down cycles 2->1->0->2.
  - Entering tens 2 clamps ones to <=3.
- Position 6: up or down toggles MERIDIEM of channel SEL.
- Position 7: up or down toggles ALARM_EN[SEL].
- Position 8: up gives SEL+1 mod NUM_ALARMS; down gives SEL-1 mod NUM_ALARMS.
- Match logic:
  - The previous-time register captures {CUR_MERIDIEM, CUR_HOUR, CUR_MIN, CUR_SEC} every cycle.
  - RING_HIT[i]=1 for exactly the cycle after the current time differs from the previous time, ALARM_EN[i]=1, and alarm i equals the current time on all fields. MERIDIEM is compared only when H24=0.
  - Multiple channels may hit in the same cycle.
  - Matching runs in all modes.
- Reset asserted mid-edit or mid-pulse: reset wins and RING_HIT is 0 the next cycle.

Optional Feature:
ALARM_ONESHOT_EN
- Defined: when RING_HIT[i] is generated, ALARM_EN[i] clears in the same edge (one-shot alarm). If a user enable-toggle of channel i lands on that same edge, the toggle result wins.
- Undefined: ALARM_EN persists and the alarm re-fires every matching day/half-day.

Test Plan:
- Reset, MODE=0, SEC=59 at cursor 0, pulse NUM_SYNC=0001 -> SEC=50; pulse 0010 -> SEC=59.
- H24=0, HOUR=9, cursor 5, up -> HOUR=11; up again -> HOUR=1; at cursor 4, HOUR=11 up -> HOUR=10.
- H24=1, HOUR=19, cursor 5, up -> HOUR=23 (tens 2, ones clamped 3); up -> HOUR=3; cursor walk 5->next -> 7 (6 skipped).
- NUM_ALARMS=4, cursor 8, down from SEL=0 -> SEL=3; cursor 7, up -> ALARM_EN=4'b1000; NUM_SYNC=0011 -> no change.
- Alarm 3 = PM 7:30:00 enabled; drive current time PM 7:29:59 -> 7:30:00 held 1000 cycles -> RING_HIT=4'b1000 for exactly one cycle. With ALARM_ONESHOT_EN, ALARM_EN[3]=0 after the hit.
- MODE=4'b0001, pulse all NUM_SYNC bits -> CURSOR, SEL and alarm values unchanged; RESET=1 mid-sequence -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/alarm_bank_set_if.sv
`default_nettype none
// ============================================================================
// Module   : alarm_bank_set_if
// Brief    : Button/mode/time inputs and selected-alarm view of alarm_bank_set
// Revision : 1.0
// ============================================================================
interface alarm_bank_set_if #(
    parameter int NUM_ALARMS = 4
) ();
    localparam int SEL_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;

    logic [3:0]            NUM_SYNC;
    logic [3:0]            MODE;
    logic                  CUR_MERIDIEM;
    logic [6:0]            CUR_HOUR;
    logic [6:0]            CUR_MIN;
    logic [6:0]            CUR_SEC;
    logic [3:0]            CURSOR;
    logic [SEL_W-1:0]      SEL;
    logic                  MERIDIEM;
    logic [6:0]            HOUR;
    logic [6:0]            MIN;
    logic [6:0]            SEC;
    logic [NUM_ALARMS-1:0] ALARM_EN;
    logic [NUM_ALARMS-1:0] RING_HIT;

    modport master (
        output NUM_SYNC, MODE, CUR_MERIDIEM, CUR_HOUR, CUR_MIN, CUR_SEC,
        input  CURSOR, SEL, MERIDIEM, HOUR, MIN, SEC, ALARM_EN, RING_HIT
    );

    modport slave (
        input  NUM_SYNC, MODE, CUR_MERIDIEM, CUR_HOUR, CUR_MIN, CUR_SEC,
        output CURSOR, SEL, MERIDIEM, HOUR, MIN, SEC, ALARM_EN, RING_HIT
    );
endinterface
`default_nettype wire

// File: rtl/alarm_bank_set.sv
`default_nettype none
// ============================================================================
// Module   : alarm_bank_set
// Brief    : Multi-channel alarm editor and matcher; optional one-shot alarms
//            via macro ALARM_ONESHOT_EN.
// Revision : 1.0
// ============================================================================
module alarm_bank_set #(
    parameter int         NUM_ALARMS  = 4,
    parameter logic [3:0] ACTIVE_MODE = 4'b0000,
    parameter bit         H24         = 1'b0
) (
    input  wire logic        CLK,
    input  wire logic        RESET,
    alarm_bank_set_if.slave  bus
);
    localparam int SEL_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;
`ifdef ALARM_ONESHOT_EN
    localparam bit c_ONESHOT = 1'b1;
`else
    localparam bit c_ONESHOT = 1'b0;
`endif

    logic [3:0]            r_cursor;
    logic [SEL_W-1:0]      r_sel;
    logic [6:0]            r_sec  [NUM_ALARMS];
    logic [6:0]            r_min  [NUM_ALARMS];
    logic [6:0]            r_hour [NUM_ALARMS];
    logic                  r_mer  [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] r_en;
    logic [NUM_ALARMS-1:0] r_hit;
    logic [21:0]           r_prev;

    logic                  w_active, w_up, w_dn, w_nx, w_pv;
    logic                  w_changed;
    logic [NUM_ALARMS-1:0] w_hit;
    logic [6:0]            w_cur_sec, w_cur_min, w_cur_hour;
    logic                  w_cur_mer;
    logic [6:0]            w_nxt_sec, w_nxt_min, w_nxt_hour;
    logic                  w_nxt_mer, w_tog_en;
    logic [SEL_W-1:0]      w_nxt_sel;
    logic [3:0]            w_nxt_cursor;

    // Ones digit wraps inside its own tens group (x9 <-> x0).
    function automatic logic [6:0] f_ones(input logic [6:0] v, input logic up);
        logic [6:0] base;
        base = (v / 7'd10) * 7'd10;
        if (up) return ((v - base) == 7'd9) ? base : v + 7'd1;
        else    return (v == base) ? base + 7'd9 : v - 7'd1;
    endfunction

    function automatic logic [6:0] f_tens(input logic [6:0] v, input logic up);
        if (up) return (v >= 7'd50) ? v - 7'd50 : v + 7'd10;
        else    return (v < 7'd10)  ? v + 7'd50 : v - 7'd10;
    endfunction

    function automatic logic [6:0] f_hour_ones(input logic [6:0] h, input logic up);
        logic [6:0] tens, base, lim;
        tens = h / 7'd10;
        base = tens * 7'd10;
        if (tens == 7'd2)             lim = 7'd3;
        else if (!H24 && tens == 7'd1) lim = 7'd1;
        else                           lim = 7'd9;
        if (up) return ((h - base) == lim) ? base : h + 7'd1;
        else    return (h == base) ? base + lim : h - 7'd1;
    endfunction

    function automatic logic [6:0] f_hour_tens(input logic [6:0] h, input logic up);
        logic [6:0] tens, ones, ones_cl;
        tens    = h / 7'd10;
        ones    = h - tens * 7'd10;
        ones_cl = (ones > 7'd3) ? 7'd3 : ones;
        if (!H24) begin
            if (h >= 7'd10)     return h - 7'd10;
            else if (h <= 7'd1) return h + 7'd10;
            else                return 7'd11;
        end
        if (up) begin
            if (tens == 7'd0)      return h + 7'd10;
            else if (tens == 7'd1) return 7'd20 + ones_cl;
            else                   return ones;
        end
        if (tens == 7'd2)      return 7'd10 + ones;
        else if (tens == 7'd1) return ones;
        else                   return 7'd20 + ones_cl;
    endfunction

    function automatic logic [3:0] f_cur_next(input logic [3:0] c);
        if (c == 4'd8)            return 4'd0;
        else if (H24 && c == 4'd5) return 4'd7;
        else                       return c + 4'd1;
    endfunction

    function automatic logic [3:0] f_cur_prev(input logic [3:0] c);
        if (c == 4'd0)            return 4'd8;
        else if (H24 && c == 4'd7) return 4'd5;
        else                       return c - 4'd1;
    endfunction

    assign w_active = (bus.MODE == ACTIVE_MODE);
    assign w_up     = w_active &&  bus.NUM_SYNC[0] && !bus.NUM_SYNC[1];
    assign w_dn     = w_active && !bus.NUM_SYNC[0] &&  bus.NUM_SYNC[1];
    assign w_nx     = w_active &&  bus.NUM_SYNC[2] && !bus.NUM_SYNC[3];
    assign w_pv     = w_active && !bus.NUM_SYNC[2] &&  bus.NUM_SYNC[3];

    assign w_changed = ({bus.CUR_MERIDIEM, bus.CUR_HOUR, bus.CUR_MIN, bus.CUR_SEC} != r_prev);

    for (genvar gi = 0; gi < NUM_ALARMS; gi++) begin : g_match
        assign w_hit[gi] = w_changed && r_en[gi]
                        && (r_sec[gi]  == bus.CUR_SEC)
                        && (r_min[gi]  == bus.CUR_MIN)
                        && (r_hour[gi] == bus.CUR_HOUR)
                        && (H24 || (r_mer[gi] == bus.CUR_MERIDIEM));
    end

    always_comb begin
        w_cur_sec  = r_sec[0];
        w_cur_min  = r_min[0];
        w_cur_hour = r_hour[0];
        w_cur_mer  = r_mer[0];
        for (int i = 0; i < NUM_ALARMS; i++) begin
            if (r_sel == SEL_W'(i)) begin
                w_cur_sec  = r_sec[i];
                w_cur_min  = r_min[i];
                w_cur_hour = r_hour[i];
                w_cur_mer  = r_mer[i];
            end
        end
    end

    // Edits act on the cursor position held before any same-cycle cursor move.
    always_comb begin
        w_nxt_sec  = w_cur_sec;
        w_nxt_min  = w_cur_min;
        w_nxt_hour = w_cur_hour;
        w_nxt_mer  = w_cur_mer;
        w_tog_en   = 1'b0;
        w_nxt_sel  = r_sel;
        if (w_up || w_dn) begin
            case (r_cursor)
                4'd0: w_nxt_sec  = f_ones(w_cur_sec, w_up);
                4'd1: w_nxt_sec  = f_tens(w_cur_sec, w_up);
                4'd2: w_nxt_min  = f_ones(w_cur_min, w_up);
                4'd3: w_nxt_min  = f_tens(w_cur_min, w_up);
                4'd4: w_nxt_hour = f_hour_ones(w_cur_hour, w_up);
                4'd5: w_nxt_hour = f_hour_tens(w_cur_hour, w_up);
                4'd6: if (!H24) w_nxt_mer = ~w_cur_mer;
                4'd7: w_tog_en   = 1'b1;
                4'd8: begin
                    if (w_up) w_nxt_sel = (r_sel == SEL_W'(NUM_ALARMS - 1)) ? '0 : r_sel + SEL_W'(1);
                    else      w_nxt_sel = (r_sel == '0) ? SEL_W'(NUM_ALARMS - 1) : r_sel - SEL_W'(1);
                end
                default: ;
            endcase
        end
        w_nxt_cursor = r_cursor;
        if (w_nx)      w_nxt_cursor = f_cur_next(r_cursor);
        else if (w_pv) w_nxt_cursor = f_cur_prev(r_cursor);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_cursor <= 4'd0;
            r_sel    <= '0;
            r_en     <= '0;
            r_hit    <= '0;
            r_prev   <= '0;
            for (int i = 0; i < NUM_ALARMS; i++) begin
                r_sec[i]  <= 7'd0;
                r_min[i]  <= 7'd0;
                r_hour[i] <= 7'd0;
                r_mer[i]  <= 1'b0;
            end
        end else begin
            r_cursor <= w_nxt_cursor;
            r_sel    <= w_nxt_sel;
            r_hit    <= w_hit;
            r_prev   <= {bus.CUR_MERIDIEM, bus.CUR_HOUR, bus.CUR_MIN, bus.CUR_SEC};
            for (int i = 0; i < NUM_ALARMS; i++) begin
                if (r_sel == SEL_W'(i)) begin
                    r_sec[i]  <= w_nxt_sec;
                    r_min[i]  <= w_nxt_min;
                    r_hour[i] <= w_nxt_hour;
                    r_mer[i]  <= w_nxt_mer;
                end
                // A user toggle on the hit edge overrides the one-shot clear.
                if (w_tog_en && r_sel == SEL_W'(i)) r_en[i] <= ~r_en[i];
                else if (c_ONESHOT && w_hit[i])     r_en[i] <= 1'b0;
            end
        end
    end

    assign bus.CURSOR   = r_cursor;
    assign bus.SEL      = r_sel;
    assign bus.MERIDIEM = H24 ? 1'b0 : w_cur_mer;
    assign bus.HOUR     = w_cur_hour;
    assign bus.MIN      = w_cur_min;
    assign bus.SEC      = w_cur_sec;
    assign bus.ALARM_EN = r_en;
    assign bus.RING_HIT = r_hit;
endmodule
`default_nettype wire
